// File: rtl/issue_queue_entry_allocator_pkg.sv
// Scheduler-wide constants and index types shared by the issue-queue blocks.
package SchedulerTypes;

    localparam int ISSUE_QUEUE_ENTRY_NUM       = 16;
    localparam int DISPATCH_WIDTH              = 2;
    localparam int ISSUE_WIDTH                 = 2;
    localparam int ISSUE_QUEUE_INDEX_BIT_WIDTH = $clog2(ISSUE_QUEUE_ENTRY_NUM);

    typedef logic [ISSUE_QUEUE_INDEX_BIT_WIDTH-1:0] IssueQueueIndexPath;
    typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]       IssueQueueOneHotPath;

endpackage

// File: rtl/issue_queue_entry_allocator_free_list.sv
// Generic circular index queue: up to POP_W pops and PUSH_W compacted pushes per cycle.
// Reset or i_init refills it with slot[i] = i and INIT_COUNT valid entries.
module multi_port_free_list_queue #(
    parameter int DEPTH      = 16,
    parameter int POP_W      = 2,
    parameter int PUSH_W     = 2,
    parameter int INIT_COUNT = DEPTH,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_init,
    input  logic [IDX_W:0]   i_pop_num,
    input  logic [IDX_W:0]   i_push_num,
    input  logic [IDX_W-1:0] i_push_data [PUSH_W],
    output logic [IDX_W-1:0] o_pop_data  [POP_W],
    output logic [IDX_W:0]   o_count
);

    logic [IDX_W-1:0] r_slot [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    // Head-relative peek; index arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        for (int k = 0; k < POP_W; k++) begin
            o_pop_data[k] = r_slot[r_head + IDX_W'(k)];
        end
    end

    assign o_count = r_count;

    // NOTE: the slot array is reset deliberately; its contents are the free pool, not scratch data.
    always_ff @(posedge clk) begin
        if (!rst || i_init) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= IDX_W'(i);
            end
            r_head  <= '0;
            r_tail  <= IDX_W'(INIT_COUNT);
            r_count <= (IDX_W+1)'(INIT_COUNT);
        end else begin
            for (int k = 0; k < PUSH_W; k++) begin
                if ((IDX_W+1)'(k) < i_push_num) begin
                    r_slot[r_tail + IDX_W'(k)] <= i_push_data[k];
                end
            end
            r_head  <= r_head + i_pop_num[IDX_W-1:0];
            r_tail  <= r_tail + i_push_num[IDX_W-1:0];
            r_count <= r_count - i_pop_num + i_push_num;
        end
    end

endmodule

// File: rtl/issue_queue_entry_allocator.sv
// Issue-queue entry pool: grants free indices to dispatch, reclaims them from wakeup,
// tracks occupancy and flags illegal allocation / release attempts.
module issue_queue_entry_allocator #(
    parameter int ENTRY_NUM      = SchedulerTypes::ISSUE_QUEUE_ENTRY_NUM,
    parameter int DISPATCH_WIDTH = SchedulerTypes::DISPATCH_WIDTH,
    parameter int RELEASE_WIDTH  = SchedulerTypes::ISSUE_WIDTH,
    parameter int INDEX_W        = $clog2(ENTRY_NUM)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [DISPATCH_WIDTH-1:0]         allocReq,
    output logic [DISPATCH_WIDTH*INDEX_W-1:0] allocPtr,
    output logic                              allocatable,
    input  logic [RELEASE_WIDTH-1:0]          releaseEntry,
    input  logic [RELEASE_WIDTH*INDEX_W-1:0]  releasePtr,
    output logic [INDEX_W:0]                  freeCount,
    output logic [ENTRY_NUM-1:0]              busyVector,
    output logic                              allocError,
    output logic                              releaseError
);

    logic [INDEX_W-1:0]   w_head_data [DISPATCH_WIDTH];
    logic [INDEX_W-1:0]   w_push_data [RELEASE_WIDTH];
    logic [INDEX_W:0]     w_count;
    logic [INDEX_W:0]     w_n_alloc;
    logic [INDEX_W:0]     w_pop_num;
    logic [INDEX_W:0]     w_push_num;
    logic                 w_alloc_ok;
    logic                 w_rel_bad;
    logic [ENTRY_NUM-1:0] w_set;
    logic [ENTRY_NUM-1:0] w_clr;

    logic [ENTRY_NUM-1:0] r_busy;
    logic                 r_alloc_err;
    logic                 r_rel_err;

    // A compacted request is a run of ones from lane 0, so x & (x+1) is zero.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin : alloc_path
        allocPtr  = '0;
        w_set     = '0;
        w_n_alloc = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            w_n_alloc = w_n_alloc + (INDEX_W+1)'(allocReq[k]);
        end
        w_alloc_ok = ((allocReq & (allocReq + DISPATCH_WIDTH'(1))) == '0) && (w_n_alloc <= w_count);
        w_pop_num  = w_alloc_ok ? w_n_alloc : '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            allocPtr[k*INDEX_W +: INDEX_W] = w_head_data[k];
            if (w_alloc_ok && allocReq[k]) begin
                w_set[w_head_data[k]] = 1'b1;
            end
        end
    end

    always_comb begin : release_path
        logic v_dup;
        int   v_n;
        v_n       = 0;
        v_dup     = 1'b0;
        w_clr     = '0;
        w_rel_bad = 1'b0;
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            w_push_data[j] = '0;
        end
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            v_dup = 1'b0;
            for (int i = 0; i < j; i++) begin
                if (releaseEntry[i] && (releasePtr[i*INDEX_W +: INDEX_W] == releasePtr[j*INDEX_W +: INDEX_W])) begin
                    v_dup = 1'b1;
                end
            end
            if (releaseEntry[j]) begin
                if (r_busy[releasePtr[j*INDEX_W +: INDEX_W]] && !v_dup) begin
                    w_push_data[v_n] = releasePtr[j*INDEX_W +: INDEX_W];
                    w_clr[releasePtr[j*INDEX_W +: INDEX_W]] = 1'b1;
                    v_n = v_n + 1;
                end else begin
                    w_rel_bad = 1'b1;
                end
            end
        end
        w_push_num = (INDEX_W+1)'(v_n);
    end

    multi_port_free_list_queue #(
        .DEPTH      (ENTRY_NUM),
        .POP_W      (DISPATCH_WIDTH),
        .PUSH_W     (RELEASE_WIDTH),
        .INIT_COUNT (ENTRY_NUM),
        .IDX_W      (INDEX_W)
    ) u_free_list (
        .clk         (clk),
        .rst         (rst),
        .i_init      (flush),
        .i_pop_num   (w_pop_num),
        .i_push_num  (w_push_num),
        .i_push_data (w_push_data),
        .o_pop_data  (w_head_data),
        .o_count     (w_count)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy      <= '0;
            r_alloc_err <= 1'b0;
            r_rel_err   <= 1'b0;
        end else if (flush) begin
            r_busy      <= '0;
        end else begin
            r_busy      <= (r_busy & ~w_clr) | w_set;
            r_alloc_err <= r_alloc_err | !w_alloc_ok;
            r_rel_err   <= r_rel_err | w_rel_bad;
        end
    end

    assign allocatable  = (w_count >= (INDEX_W+1)'(DISPATCH_WIDTH));
    assign freeCount    = w_count;
    assign busyVector   = r_busy;
    assign allocError   = r_alloc_err;
    assign releaseError = r_rel_err;

    // Every entry is either in the free pool or marked busy, never both, never neither.
    a_pool_conserved: assert property (@(posedge clk) disable iff (!rst)
        (32'(freeCount) + $countones(busyVector)) == ENTRY_NUM);

endmodule
